pmem_boot_loader: RTL and testbench
===================================

# pmem_boot_loader

Boot-time sequencer for the program memory. It receives a framed byte stream from a host link (UART receiver or debug port), writes the payload byte-by-byte into program memory through its write port starting at address 0, and verifies an 8-bit checksum. It holds the CPU core in reset-hold until a valid image is resident. It sits between the host receiver and the program memory write port, in parallel with the fetch path.

## Interface
- `PC_WIDTH`, 12: program memory address width; capacity 2**PC_WIDTH bytes.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles between accepted bytes once a frame has started.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; arms a new load from IDLE, DONE or ERR.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `mem_w_en`  out  1  program memory byte write strobe.
- `mem_addr`  out  PC_WIDTH  write address.
- `mem_wdata`  out  8  write byte.
- `cpu_hold`  out  1  keeps the core in reset/stall while high.
- `done`  out  1  valid image loaded (level).
- `error`  out  1  load failed (level).
- `err_code`  out  2  0 none, 1 length overflow, 2 checksum mismatch, 3 timeout.
- `byte_count`  out  PC_WIDTH+1  payload bytes written in the current or last load.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit little-endian length N), N payload bytes, CSUM. CSUM is the 8-bit modular sum of the payload bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- A byte is accepted on a rising edge with `rx_valid && rx_ready`.
- `rx_ready` is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 elsewhere.
- IDLE/DONE/ERR + `start` -> LEN_LO:
  - clears `done`, `error`, `err_code`, `byte_count` and the checksum accumulator;
  - sets `cpu_hold`=1.
- LEN_LO: the accepted byte goes to `len[7:0]`; next state LEN_HI.
- LEN_HI: the accepted byte goes to `len[15:8]`.
  - If the new length exceeds 2**PC_WIDTH -> ERR, code 1.
  - Else if length = 0 -> CSUM.
  - Else -> DATA.
- DATA: each accepted byte is written to address `byte_count`, added to the accumulator, and increments `byte_count`. The last byte (`byte_count` = len-1) -> CSUM.
- CSUM: accepted byte equal to the accumulator -> DONE (`done`=1, `cpu_hold`=0). Otherwise -> ERR, code 2.
- Timeout: in LEN_HI, DATA and CSUM, an idle counter increments on every cycle with no accepted byte and clears on acceptance. Reaching TIMEOUT_CYCLES -> ERR, code 3. LEN_LO waits indefinitely.
- ERR: `error`=1, `cpu_hold` stays 1, and memory contents are left as partially written. Only `start` or `rst` leaves ERR.
- `start` outside IDLE/DONE/ERR is ignored.
- A `start` pulse in the same cycle as a byte acceptance in DONE/ERR cannot occur, because `rx_ready`=0 in those states.

## Timing
- Reset values:
  - state IDLE, `cpu_hold`=1;
  - `rx_ready`, `mem_w_en`, `done`, `error` = 0;
  - `err_code`=0, `byte_count`=0;
  - `mem_addr`=0, `mem_wdata`=0.
- `mem_w_en`, `mem_addr` and `mem_wdata` are registered: asserted for exactly one cycle, the cycle after the DATA acceptance edge. Back-to-back bytes give back-to-back writes with consecutive addresses.
- Throughput is one byte per cycle, with no bubbles.
- `done`, `error`, `err_code` and `cpu_hold` update on the same edge as the state transition.
- `rst` mid-load aborts immediately: the next cycle shows reset values, no further writes occur, and there is no memory clear.
- Address wrap cannot occur; the maximum length is 2**PC_WIDTH, with the last address 2**PC_WIDTH-1.

## Structure
- Shared package/header (alongside the common library): state encodings (3-bit), err_code constants (`ERR_NONE`, `ERR_LEN`, `ERR_CSUM`, `ERR_TIMEOUT`).
- One sub-module: `idle_timer`, a saturating counter with `clear` and `expired` outputs, parameterised on TIMEOUT_CYCLES.
- Everything else is a single FSM with datapath registers: len, acc, byte_count.

## Test plan
- Nominal load, PC_WIDTH=12: `start`, then bytes 04 00 13 01 30 00 44. Expect writes 0x13@0, 0x01@1, 0x30@2, 0x00@3, then `done`=1, `cpu_hold`=0, `err_code`=0, `byte_count`=4.
- Bad checksum: same frame with CSUM 45. Expect 4 writes, then `error`=1, `err_code`=2, `cpu_hold`=1, `done`=0.
- Length overflow: LEN 01 10 (0x1001). Expect ERR, `err_code`=1, zero writes, `rx_ready`=0 afterwards.
- Zero length and full length:
  - 00 00 00 -> DONE with no writes.
  - 00 10, 4096 bytes of 0x01, CSUM 0x00 -> DONE; last write at address 0xFFF.
- Timeout with TIMEOUT_CYCLES=16: stall `rx_valid` for 16 cycles after the 2nd payload byte. Expect ERR, `err_code`=3. Then `start` and a nominal frame -> DONE.
- Reset mid-DATA after 2 writes: all outputs at reset values next cycle, `cpu_hold`=1, `rx_ready`=0, no further `mem_w_en`. Also check `start` while in DATA is ignored.

Source files
------------

// File: rtl/pmem_boot_loader_pkg.sv
// Shared encodings for the program-memory boot loader: FSM states and
// the error codes reported on err_code.
package pmem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/pmem_boot_loader_idle_timer.sv
// Saturating idle counter: counts cycles while clear is low and flags the
// cycle on which the TIMEOUT_CYCLES-th consecutive idle cycle completes.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires during the idle cycle that would bring the count to TIMEOUT_CYCLES.
    assign expired = !clear && (cnt == LAST);

endmodule

// File: rtl/pmem_boot_loader.sv
// Boot loader: receives LEN_LO, LEN_HI, payload, CSUM from the host link,
// writes the payload into program memory from address 0 and holds the CPU.
module pmem_boot_loader
    import pmem_boot_loader_pkg::*;
#(
    parameter int PC_WIDTH       = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                mem_w_en,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [PC_WIDTH:0]   byte_count
);
    localparam int              MAX_LEN = 1 << PC_WIDTH;
    localparam logic [PC_WIDTH:0] CNT_ONE = 1;

    state_t            state, state_n;
    logic [15:0]       len, len_n, new_len;
    logic [7:0]        acc, acc_n;
    logic [PC_WIDTH:0] count_n;
    logic              done_n, error_n, hold_n, we_n;
    logic [1:0]        code_n;
    logic [PC_WIDTH-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic              accept, timed, expired;

    assign rx_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CSUM);
    assign accept   = rx_valid && rx_ready;
    assign timed    = (state == ST_LEN_HI) || (state == ST_DATA) || (state == ST_CSUM);
    assign new_len  = {rx_data, len[7:0]};

    // LEN_LO is excluded from the timer so the host may start a frame at leisure.
    idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!timed || accept),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        len_n   = len;
        acc_n   = acc;
        count_n = byte_count;
        done_n  = done;
        error_n = error;
        code_n  = err_code;
        hold_n  = cpu_hold;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n = ST_LEN_LO;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    code_n  = ERR_NONE;
                    count_n = '0;
                    acc_n   = '0;
                    hold_n  = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_n[7:0] = rx_data;
                    state_n    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_n = new_len;
                    if (32'(new_len) > MAX_LEN) begin
                        state_n = ST_ERR;
                        error_n = 1'b1;
                        code_n  = ERR_LEN;
                    end else if (new_len == 16'd0) begin
                        state_n = ST_CSUM;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else if (expired) begin
                    state_n = ST_ERR;
                    error_n = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    we_n    = 1'b1;
                    addr_n  = byte_count[PC_WIDTH-1:0];
                    wdata_n = rx_data;
                    acc_n   = acc + rx_data;
                    count_n = byte_count + CNT_ONE;
                    if (32'(byte_count) + 32'd1 == 32'(len)) state_n = ST_CSUM;
                end else if (expired) begin
                    state_n = ST_ERR;
                    error_n = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == acc) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
                    end else begin
                        state_n = ST_ERR;
                        error_n = 1'b1;
                        code_n  = ERR_CSUM;
                    end
                end else if (expired) begin
                    state_n = ST_ERR;
                    error_n = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            acc        <= '0;
            byte_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            cpu_hold   <= 1'b1;
            mem_w_en   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            acc        <= acc_n;
            byte_count <= count_n;
            done       <= done_n;
            error      <= error_n;
            err_code   <= code_n;
            cpu_hold   <= hold_n;
            mem_w_en   <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
        end
    end

endmodule

// File: tb/tb_pmem_boot_loader.sv
// Scoreboarded bench for pmem_boot_loader: frames are modelled as whole
// images, expected writes and final status are queued, a monitor compares.
module tb_pmem_boot_loader;
    localparam int PW  = 12;
    localparam int TO  = 16;
    localparam int CAP = 1 << PW;

    logic          clk = 1'b0;
    logic          rst, start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready, mem_w_en, cpu_hold, done, error;
    logic [PW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [1:0]    err_code;
    logic [PW:0]   byte_count;

    pmem_boot_loader #(.PC_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
        .err_code(err_code), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PW-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic dn; logic er; logic [1:0] code; int count; } st_t;

    int         total = 0;
    int         bad = 0;
    wr_t        wr_q[$];
    st_t        st_q[$];
    logic [7:0] payload[$];
    logic       fin_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected write per strobe, an expected status per finish.
    always @(negedge clk) begin : monitor
        wr_t w;
        st_t s;
        if (mem_w_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.addr));
                check("wr_data", 32'(mem_wdata), 32'(w.data));
            end
        end
        if ((done | error) === 1'b1 && fin_d !== 1'b1) begin
            if (st_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_finish: got done %0b error %0b expected none", done, error);
            end else begin
                s = st_q.pop_front();
                check("done",       32'(done),       32'(s.dn));
                check("error",      32'(error),      32'(s.er));
                check("err_code",   32'(err_code),   32'(s.code));
                check("byte_count", 32'(byte_count), 32'(s.count));
                check("cpu_hold",   32'(cpu_hold),   32'(!s.dn));
                check("rx_ready",   32'(rx_ready),   32'd0);
            end
        end
        fin_d <= done | error;
    end

    function automatic logic [7:0] psum();
        logic [7:0] s = 8'd0;
        foreach (payload[i]) s = s + payload[i];
        return s;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, "_mem_w_en"},   32'(mem_w_en),   32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_err_code"},   32'(err_code),   32'd0);
        check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    endtask

    // Reference model: outcome of an image load from the frame's own rules.
    // stall_after >= 0: only that many frame bytes are offered, then the link idles.
    task automatic run_frame(input int lenf, input logic [7:0] csum, input int stall_after,
                             input int long_gap_at, input bit rand_gaps);
        logic [7:0] fb[$];
        st_t        s;
        int         nw, n_send, gap;
        bit         ok, fin;
        logic [15:0] l16;
        l16 = 16'(lenf);
        fb.push_back(l16[7:0]);
        fb.push_back(l16[15:8]);
        if (lenf <= CAP) begin
            foreach (payload[i]) fb.push_back(payload[i]);
            fb.push_back(csum);
        end
        n_send = (stall_after >= 0) ? stall_after : fb.size();
        if (lenf > CAP) begin
            nw = 0; s = '{1'b0, 1'b1, 2'd1, 0};
        end else if (stall_after >= 0) begin
            nw = stall_after - 2;
            if (nw < 0) nw = 0;
            if (nw > lenf) nw = lenf;
            s = '{1'b0, 1'b1, 2'd3, nw};
        end else begin
            nw = lenf;
            s = (csum == psum()) ? '{1'b1, 1'b0, 2'd0, lenf} : '{1'b0, 1'b1, 2'd2, lenf};
        end
        for (int i = 0; i < nw; i++) wr_q.push_back('{PW'(i), payload[i]});
        st_q.push_back(s);
        pulse_start();
        for (int i = 0; i < n_send; i++) begin
            gap = (i == long_gap_at) ? TO - 1 : (rand_gaps ? $urandom_range(0, 3) : 0);
            send_byte(fb[i], gap, ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL rx_ready_wait: got no acceptance of byte %0d expected accept", i);
                return;
            end
        end
        fin = 1'b0;
        for (int i = 0; i < TO + 50; i++) begin
            @(negedge clk);
            if (done || error) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL finish_wait: got no done/error expected one within %0d cycles", TO + 50);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int n;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Nominal image, then the same image with a corrupted checksum.
        payload = '{8'h13, 8'h01, 8'h30, 8'h00};
        run_frame(4, 8'h44, -1, -1, 1'b0);
        run_frame(4, 8'h45, -1, -1, 1'b1);

        // Length one past capacity.
        payload = {};
        run_frame(32'h1001, 8'h00, -1, -1, 1'b0);

        // Empty image and a full-capacity image.
        run_frame(0, 8'h00, -1, -1, 1'b0);
        payload = {};
        for (int i = 0; i < CAP; i++) payload.push_back(8'h01);
        run_frame(CAP, 8'h00, -1, -1, 1'b1);

        // Idle gap of TO-1 survives; a gap of TO after two payload bytes times out.
        payload = '{8'h13, 8'h01, 8'h30, 8'h00};
        run_frame(4, 8'h44, -1, 3, 1'b0);
        run_frame(4, 8'h44, 4, -1, 1'b0);
        run_frame(4, 8'h44, -1, -1, 1'b0);

        // Randomized images, some with bad checksums or oversize lengths.
        for (int k = 0; k < 12; k++) begin
            payload = {};
            if (k % 5 == 4) begin
                run_frame(CAP + 1 + $urandom_range(0, 1000), 8'h00, -1, -1, 1'b1);
            end else begin
                n = $urandom_range(0, 40);
                for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
                run_frame(n, $urandom_range(0, 1) ? psum() : psum() ^ 8'($urandom_range(1, 255)),
                          -1, -1, 1'b1);
            end
        end

        // Reset mid-DATA; a start pulse inside DATA must be ignored.
        payload = {};
        for (int i = 0; i < 8; i++) payload.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) wr_q.push_back('{PW'(i), payload[i]});
        pulse_start();
        send_byte(8'h08, 0, ok);
        send_byte(8'h00, 0, ok);
        send_byte(payload[0], 0, ok);
        send_byte(payload[1], 0, ok);
        pulse_start();
        send_byte(payload[2], 0, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL start_in_data: got byte refused expected accept");
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        rx_valid = 1'b1; rx_data = 8'h5A;
        repeat (4) @(negedge clk);
        check("post_reset_ready", 32'(rx_ready), 32'd0);
        check("post_reset_hold",  32'(cpu_hold), 32'd1);
        rx_valid = 1'b0;

        check("wr_q_left", 32'(wr_q.size()), 32'd0);
        check("st_q_left", 32'(st_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
